// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and the compare-mask helper for the programmable
// serial pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_e;

  // Ones in the low len bit positions; callers truncate to their window width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Serial history window: shift register, fill counter and masked comparator.
// hit_o is combinational and only asserts on a bit being shifted in.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               din_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               hit_o,
  output logic               full_o
);

  // The incoming bit completes the window, so only MAX_LEN-1 history bits are kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;

  assign window   = {hist_q, din_i};
  assign mask     = MAX_LEN'(len_mask(32'(len_i)));
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign full_o   = (fill_inc >= {1'b0, len_i});
  assign hit_o    = shift_i && full_o && (((window ^ pat_i) & mask) == '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = window[MAX_LEN-2:0];
      if (fill_inc <= {1'b0, len_i}) fill_d = fill_inc[LEN_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control and config check.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               match,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W:0] MAX_LEN_L = (LEN_W+1)'(MAX_LEN);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic cfg_ok;
  logic accept;
  logic hit;
  logic full;
  logic win_clr;

  assign cfg_ok  = (pat_len != '0) && ({1'b0, pat_len} <= MAX_LEN_L);
  // cfg_load takes priority: a bit arriving with it is dropped.
  assign accept  = din_valid && (state_q != IDLE) && !cfg_load;
  assign win_clr = cfg_load || (hit && !overlap_q);

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (win_clr),
    .shift_i (accept),
    .din_i   (din),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .hit_o   (hit),
    .full_o  (full)
  );

  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    match_d   = hit;
    if (cfg_load) begin
      state_d   = cfg_ok ? FILL : IDLE;
      cfg_err_d = !cfg_ok;
    end else if (accept) begin
      if (hit && !overlap_q) state_d = FILL;
      else if (full)         state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
      if (cfg_load) begin
        pat_q     <= pat;
        len_q     <= pat_len;
        overlap_q <= overlap;
      end
    end
  end

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load)                 cnt_d = '0;
    else if (hit && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: table of cycle vectors plus hand-written
// reset sequences; a second instance with a 2-bit counter covers saturation.
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic       overlap;
  logic       din_valid;
  logic       din;

  logic        match,     cfg_err;
  logic [15:0] match_count;
  logic        sat_match, sat_cfg_err;
  logic [1:0]  sat_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .pat         (pat),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .din_valid   (din_valid),
    .din         (din),
    .match       (match),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .pat         (pat),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .din_valid   (din_valid),
    .din         (din),
    .match       (sat_match),
    .cfg_err     (sat_cfg_err),
    .match_count (sat_count)
  );

  typedef struct {
    logic       cl;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       dv;
    logic       din;
    logic       exp_match;
    logic       exp_err;
    int         n_match;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cl, input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic dv, input logic d,
                     input logic em, input logic ee, input int n, input string name);
    vec_t v;
    v.cl = cl; v.pat = p; v.len = l; v.ovl = o; v.dv = dv; v.din = d;
    v.exp_match = em; v.exp_err = ee; v.n_match = n; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the sampling edge.
  task automatic drive(input logic cl, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic dv, input logic d);
    cfg_load = cl; pat = p; pat_len = l; overlap = o; din_valid = dv; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic em, input logic ee, input int n);
    int exp_main, exp_sat;
    exp_main = CNT_ON ? n : 0;
    exp_sat  = CNT_ON ? ((n > 3) ? 3 : n) : 0;
    check({name, ".match"},     32'(match),       32'(em));
    check({name, ".sat_match"}, 32'(sat_match),   32'(em));
    check({name, ".cfg_err"},   32'(cfg_err),     32'(ee));
    check({name, ".count"},     32'(match_count), 32'(exp_main));
    check({name, ".sat_count"}, 32'(sat_count),   32'(exp_sat));
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    // Overlapping 101 on 10101; live config lines are zeroed to prove shadow use.
    add(1, 8'h05, 3, 1, 0, 0, 0, 0, 0, "ovl_cfg");
    add(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, "ovl_b1");
    add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, "ovl_b2");
    add(0, 8'h00, 0, 0, 1, 1, 1, 0, 1, "ovl_b3");
    add(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, "ovl_b4");
    add(0, 8'h00, 0, 0, 1, 1, 1, 0, 2, "ovl_b5");
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 2, "ovl_gap");
    // Non-overlapping: history cleared after the first hit.
    add(1, 8'h05, 3, 0, 0, 0, 0, 0, 0, "novl_cfg");
    add(0, 8'h00, 0, 1, 1, 1, 0, 0, 0, "novl_b1");
    add(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, "novl_b2");
    add(0, 8'h00, 0, 1, 1, 1, 1, 0, 1, "novl_b3");
    add(0, 8'h00, 0, 1, 1, 0, 0, 0, 1, "novl_b4");
    add(0, 8'h00, 0, 1, 1, 1, 0, 0, 1, "novl_b5");
    // Full-length 0xA5 with an inverted bit offered while din_valid is low.
    add(1, 8'hA5, 8, 1, 0, 0, 0, 0, 0, "a5_cfg");
    for (int i = 7; i >= 0; i--) begin
      add(0, 8'h00, 0, 0, 1, a5[i], (i == 0), 0, (i == 0) ? 1 : 0, $sformatf("a5_bit%0d", i));
      add(0, 8'h00, 0, 0, 0, ~a5[i], 0, 0, (i == 0) ? 1 : 0, $sformatf("a5_gap%0d", i));
    end
    // cfg_load on the final pattern bit: bit dropped, history cleared.
    add(1, 8'h05, 3, 1, 0, 0, 0, 0, 0, "clash_cfg");
    add(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, "clash_b1");
    add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, "clash_b2");
    add(1, 8'h05, 3, 1, 1, 1, 0, 0, 0, "clash_load");
    add(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, "clash_after1");
    add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, "clash_after2");
    add(0, 8'h00, 0, 0, 1, 1, 1, 0, 1, "clash_after3");
    // Illegal lengths leave the block idle with cfg_err set.
    add(1, 8'h05, 0, 1, 0, 0, 0, 1, 0, "len0_cfg");
    add(0, 8'h00, 0, 0, 1, 1, 0, 1, 0, "len0_bit");
    add(1, 8'h01, 9, 1, 0, 0, 0, 1, 0, "len9_cfg");
    add(0, 8'h00, 0, 0, 1, 1, 0, 1, 0, "len9_bit");
    // len=1: every matching bit pulses; the 2-bit counter saturates at 3.
    add(1, 8'h01, 1, 1, 0, 0, 0, 0, 0, "len1_cfg");
    for (int k = 1; k <= 6; k++)
      add(0, 8'h00, 0, 0, 1, 1, 1, 0, k, $sformatf("len1_one%0d", k));
    add(0, 8'h00, 0, 0, 1, 0, 0, 0, 6, "len1_zero");

    // Reset, then data with no configuration.
    reset = 1'b1;
    cfg_load = 1'b0; pat = '0; pat_len = '0; overlap = 1'b0; din_valid = 1'b0; din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 1, 0);
    reset = 1'b0;
    drive(0, 8'h00, 0, 0, 1, 1); check_all("unconf_b1", 0, 1, 0);
    drive(0, 8'h00, 0, 0, 1, 0); check_all("unconf_b2", 0, 1, 0);
    drive(0, 8'h00, 0, 0, 1, 1); check_all("unconf_b3", 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].cl, vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].dv, vecs[i].din);
      check_all(vecs[i].name, vecs[i].exp_match, vecs[i].exp_err, vecs[i].n_match);
    end

    // Reset mid-pattern after 1,0: block must need a fresh cfg_load.
    drive(1, 8'h05, 3, 1, 0, 0); check_all("mid_cfg", 0, 0, 0);
    drive(0, 8'h00, 0, 0, 1, 1); check_all("mid_b1", 0, 0, 0);
    drive(0, 8'h00, 0, 0, 1, 0); check_all("mid_b2", 0, 0, 0);
    reset = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0); check_all("mid_reset", 0, 1, 0);
    reset = 1'b0;
    drive(0, 8'h05, 3, 1, 1, 1); check_all("mid_after1", 0, 1, 0);
    drive(0, 8'h05, 3, 1, 1, 0); check_all("mid_after2", 0, 1, 0);
    drive(0, 8'h05, 3, 1, 1, 1); check_all("mid_after3", 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
